// File: rtl/cnt_sweep_pkg.sv
// cnt_sweep_pkg: shared state encoding and default sizes for the counter sweep sequencer
package cnt_sweep_pkg;
    localparam int DEF_W        = 4;
    localparam int DEF_SWP_W    = 4;
    localparam int DEF_PIPE_LAT = 3;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEEK = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_FIN  = 3'd4
    } state_t;
endpackage

// File: rtl/cnt_sweep_trig.sv
// cnt_sweep_trig: combinational turn-point compare for the sweep FSM
module cnt_sweep_trig #(
    parameter int W        = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic [W-1:0] count_in,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic         hit_lo,
    output logic         hit_top,
    output logic         hit_bot
);
    localparam logic [W-1:0] LAT = W'(PIPE_LAT);
    // Turn early by the counter latency so the observed extremes land exactly on lo/hi
    assign hit_lo  = count_in == lo;
    assign hit_top = count_in == W'(hi - LAT);
    assign hit_bot = count_in == W'(lo + LAT);
endmodule

// File: rtl/count_sweep_ctrl.sv
// count_sweep_ctrl: sweeps an up/down counter lo->hi->lo n times via its sel line.
// Define CNT_SWEEP_DBG_EN to expose dbg_state/dbg_swp and trap count_in leaving [lo,hi].
module count_sweep_ctrl
    import cnt_sweep_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int SWP_W    = DEF_SWP_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     lo,
    input  logic [W-1:0]     hi,
    input  logic [SWP_W-1:0] n_sweeps,
    input  logic [W-1:0]     count_in,
    output logic             sel,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
`ifdef CNT_SWEEP_DBG_EN
    ,
    output logic [2:0]       dbg_state,
    output logic [SWP_W-1:0] dbg_swp
`endif
);
    localparam logic [W-1:0] MIN_SPAN = W'(2 * PIPE_LAT);

    state_t           r_state;
    logic             r_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_hi;
    logic [SWP_W-1:0] r_swp;

    logic [W-1:0]     w_span;
    logic             w_bad;
    logic             w_hit_lo;
    logic             w_hit_top;
    logic             w_hit_bot;
    logic             w_oob;

    assign w_span = hi - lo;
    assign w_bad  = (w_span < MIN_SPAN) || (lo >= hi);

    cnt_sweep_trig #(.W(W), .PIPE_LAT(PIPE_LAT)) u_trig (
        .count_in (count_in),
        .lo       (r_lo),
        .hi       (r_hi),
        .hit_lo   (w_hit_lo),
        .hit_top  (w_hit_top),
        .hit_bot  (w_hit_bot)
    );

`ifdef CNT_SWEEP_DBG_EN
    assign dbg_state = r_state;
    assign dbg_swp   = r_swp;
    assign w_oob     = (r_state == ST_UP || r_state == ST_DOWN) && (count_in < r_lo || count_in > r_hi);
`else
    assign w_oob     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_swp     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sel <= 1'b1;
                    if (start && w_bad) begin
                        r_cfg_err <= 1'b1;
                    end else if (start) begin
                        r_lo    <= lo;
                        r_hi    <= hi;
                        r_swp   <= (n_sweeps == '0) ? SWP_W'(1) : n_sweeps;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEEK;
                    end
                end
                ST_SEEK: if (w_hit_lo) r_state <= ST_UP;
                ST_UP: begin
                    if (w_hit_top) begin
                        r_sel   <= 1'b0;
                        r_state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (w_hit_bot) begin
                        r_sel   <= 1'b1;
                        r_swp   <= r_swp - SWP_W'(1);
                        r_busy  <= r_swp != SWP_W'(1);
                        r_done  <= r_swp == SWP_W'(1);
                        r_state <= (r_swp == SWP_W'(1)) ? ST_FIN : ST_UP;
                    end
                end
                ST_FIN: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_oob) begin
                r_state   <= ST_IDLE;
                r_sel     <= 1'b1;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign sel     = r_sel;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cfg_err = r_cfg_err;
endmodule
